logic_unit_mc: RTL and testbench
================================

# logic_unit_mc

Multi-cycle bitwise logic unit for the 32-bit MIPS datapath. It is the responder side of an operand/result handshake. It accepts two operands and an opcode from an initiator (ALU control or a bench driver) and computes AND/OR/XOR/NOR one slice per cycle, LSB slice first. It returns the result on a valid/ready output channel. It complements the combinational gate blocks where a registered, back-pressurable result path is needed.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width in bits.
- `SLICE`, 8, bits processed per cycle. `WIDTH` must be an integer multiple of `SLICE`. `N = WIDTH/SLICE` (4 by default).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  initiator presents an operation.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_op`  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  WIDTH  computed result.
- `out_zero`  out  1  result is all zeros; exists only with `LOGIC_UNIT_ZERO_FLAG_EN`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: latch `in_a`, `in_b` and `in_op`; clear the result register to 0; clear the slice counter to 0; go to BUSY.
- BUSY:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, compute `result[k*SLICE +: SLICE]` from the latched operands for slice `k` = counter value, then increment the counter.
  - After the slice with `k = N-1` is written, go to DONE.
  - Counter width is `$clog2(N)`, minimum 1 bit. The counter never wraps inside one operation.
- DONE:
  - `out_valid`=1.
  - `out_result` and `out_zero` are held constant.
  - On `out_valid && out_ready`: go to IDLE.
- Inputs are sampled only at the accept edge. Changes to `in_a`, `in_b` or `in_op` during BUSY or DONE have no effect.
- `in_valid` while not in IDLE is ignored and not queued. The initiator keeps `in_valid` asserted until it sees `in_ready`.
- No accept is possible in the cycle a result drains, because `in_ready`=0 in DONE.
- NOR is computed as `~(a|b)` per slice. Every opcode operates on all `WIDTH` bits; there is no sign or width extension.
- `SLICE == WIDTH` is legal: N=1, one BUSY cycle.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_result`=0.
  - `out_zero`=0.
  - latched operands 0.
  - counter 0.
- Assertion of `rst_n`=0 at any time, including mid-BUSY or in DONE with the result pending, abandons the operation immediately. The result is lost. No spurious `out_valid` follows reset deassertion.
- Latency: accept at edge T0 → `out_valid` high after edge T0+N (T0+4 by default).
- Throughput: minimum N+2 cycles per operation (accept, N busy, drain with `out_ready`=1 already high). The next accept happens no earlier than edge T0+N+2.
- `in_ready` and `out_valid` are decoded from registered state only. There are no combinational paths from inputs to outputs.
- Back-pressure: `out_ready` low holds DONE indefinitely with outputs stable.

## Configuration
- `LOGIC_UNIT_ZERO_FLAG_EN` defined:
  - The `out_zero` port exists.
  - It is registered and updated at the DONE-entry edge, equal to `result == 0`.
  - It reads 0 outside DONE.
- Undefined:
  - The `out_zero` port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then AND with A=0xFFFFFFFF, B=0x00000000 → `out_valid` high 4 cycles after the accept edge; `out_result`=0x00000000; `out_zero`=1 (macro on).
- OR with A=0x55555555, B=0xAAAAAAAA → 0xFFFFFFFF. XOR with A=0xFFFFFFFF, B=0xFFFFFFFF → 0x00000000. NOR with A=0, B=0 → 0xFFFFFFFF, `out_zero`=0.
- Back-pressure: AND with A=0x0F0F0F0F, B=0xFFFF0000 and `out_ready`=0 for 10 cycles → `out_valid` stays 1 and `out_result` stays 0x0F0F0000. Then `out_ready`=1 → exactly one transfer, and `in_ready` is 1 in the following cycle.
- Input interference: during BUSY, drive `in_valid`=1 and change `in_a`/`in_op` → the result still matches the originally accepted operands, and no second result is produced.
- Reset mid-operation: pull `rst_n` low two cycles after the accept edge → `out_valid`=0, `out_result`=0, `in_ready`=1 after release, and no result emerges.
- Back-to-back: `in_valid` held high with `out_ready`=1 for 3 operations → the accept edges are 6 cycles apart.

Source files
------------

// File: rtl/logic_unit_mc.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), one SLICE per cycle, LSB first.
// Optional registered all-zero flag on out_zero when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module logic_unit_mc #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_nx;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             last_slice;
  logic [SLICE-1:0] sa, sb, sr;

  assign last_slice = (cnt == CW'(N - 1));
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)   state_nx = BUSY;
      BUSY:    if (last_slice) state_nx = DONE;
      DONE:    if (out_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slice k of the result, merged into the held result register
  always_comb begin
    sa = a_q[int'(cnt)*SLICE +: SLICE];
    sb = b_q[int'(cnt)*SLICE +: SLICE];
    case (op_q)
      2'd0:    sr = sa & sb;
      2'd1:    sr = sa | sb;
      2'd2:    sr = sa ^ sb;
      default: sr = ~(sa | sb);
    endcase
    result_nx = result_q;
    result_nx[int'(cnt)*SLICE +: SLICE] = sr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= in_a;
          b_q      <= in_b;
          op_q     <= in_op;
          result_q <= '0;
          cnt      <= '0;
        end
        BUSY: begin
          result_q <= result_nx;
          // Hold on the last slice so the counter never wraps within an operation
          if (!last_slice) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
    end else if (state == BUSY && last_slice) begin
      out_zero <= (result_nx == '0);
    end else if (state == DONE && out_ready) begin
      out_zero <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_mc.sv
// Directed self-checking bench for logic_unit_mc (default WIDTH=32, SLICE=8, N=4).
// out_zero is checked only when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module tb_logic_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_xfer = 0;
  int acc_edge[$];
  logic [31:0] last_xfer = '0;

  logic_unit_mc #(.WIDTH(32), .SLICE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: inputs change only at posedge+1, so negedge sees what the next edge samples
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      acc_edge.push_back(cyc + 1);
      n_acc++;
    end
    if (rst_n && out_valid && out_ready) begin
      n_xfer++;
      last_xfer = out_result;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h want=00000000", out_result); end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
`endif
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input string name);
    int lat;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready got=%b want=1", name, in_ready); end
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s_latency got=%0d want=4", name, lat); end
    checks++; if (out_result !== exp) begin errors++; $display("FAIL %s_result got=%h want=%h", name, out_result, exp); end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    checks++; if (out_zero !== (exp == 32'h0)) begin errors++; $display("FAIL %s_zero got=%b want=%b", name, out_zero, exp == 32'h0); end
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s_drain got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready); end
  endtask

  task automatic test_ops;
    run_op(32'hFFFFFFFF, 32'h00000000, 2'b00, 32'h00000000, "and");
    run_op(32'h55555555, 32'hAAAAAAAA, 2'b01, 32'hFFFFFFFF, "or");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'h00000000, "xor");
    run_op(32'h00000000, 32'h00000000, 2'b11, 32'hFFFFFFFF, "nor");
    run_op(32'h12345678, 32'h0F0F00FF, 2'b10, 32'h1D3B5687, "xor_mixed");
  endtask

  task automatic test_backpressure;
    int lat, x0, bad;
    in_a = 32'h0F0F0F0F; in_b = 32'hFFFF0000; in_op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin tick; lat++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_result !== 32'h0F0F0000) bad++;
      tick;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles want=0 (last valid=%b result=%h)", bad, out_valid, out_result); end
    x0 = n_xfer;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL bp_transfers got=%0d want=1", n_xfer - x0); end
    checks++; if (last_xfer !== 32'h0F0F0000) begin errors++; $display("FAIL bp_result got=%h want=0F0F0000", last_xfer); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_after got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid); end
  endtask

  task automatic test_interference;
    int lat, a0, x0;
    a0 = n_acc; x0 = n_xfer;
    in_a = 32'h12345678; in_b = 32'hFF00FF00; in_op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_a = 32'hFFFFFFFF; in_op = 2'b11; in_valid = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick; lat++;
      in_a = in_a ^ 32'h5A5A5A5A; in_op = in_op + 2'd1;
    end
    in_valid = 1'b0;
    checks++; if (out_result !== 32'h12005600) begin errors++; $display("FAIL intf_result got=%h want=12005600", out_result); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    checks++; if (n_acc - a0 !== 1) begin errors++; $display("FAIL intf_accepts got=%0d want=1", n_acc - a0); end
    checks++; if (n_xfer - x0 !== 1 || out_valid !== 1'b0) begin errors++; $display("FAIL intf_results got=%0d valid=%b want=1 valid=0", n_xfer - x0, out_valid); end
  endtask

  task automatic test_reset_mid;
    int seen;
    in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin errors++; $display("FAIL rst_mid got valid=%b result=%h want valid=0 result=00000000", out_valid, out_result); end
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", in_ready); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_spurious got=%0d valid cycles want=0", seen); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int a0, x0, t;
    a0 = n_acc; x0 = n_xfer;
    in_a = 32'hF0F00000; in_b = 32'h00000F0F; in_op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    t = 0;
    while (n_acc < a0 + 3 && t < 60) begin tick; t++; end
    in_valid = 1'b0;
    t = 0;
    while (n_xfer < x0 + 3 && t < 60) begin tick; t++; end
    out_ready = 1'b0;
    checks++; if (n_acc - a0 !== 3 || n_xfer - x0 !== 3) begin errors++; $display("FAIL b2b_count got acc=%0d xfer=%0d want 3 and 3", n_acc - a0, n_xfer - x0); end
    if (acc_edge.size() >= a0 + 3) begin
      checks++; if (acc_edge[a0+1] - acc_edge[a0] !== 6) begin errors++; $display("FAIL b2b_gap1 got=%0d want=6", acc_edge[a0+1] - acc_edge[a0]); end
      checks++; if (acc_edge[a0+2] - acc_edge[a0+1] !== 6) begin errors++; $display("FAIL b2b_gap2 got=%0d want=6", acc_edge[a0+2] - acc_edge[a0+1]); end
    end else begin
      errors++; checks++;
      $display("FAIL b2b_edges got=%0d accepts want=3", acc_edge.size() - a0);
    end
    checks++; if (last_xfer !== 32'hF0F00F0F) begin errors++; $display("FAIL b2b_result got=%h want=F0F00F0F", last_xfer); end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_backpressure;
    test_interference;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
